// File: rtl/lms_pkg.sv
// Shared sample type and saturating subtract for the LMS error path.
// Pure definitions: no state, no handshake.
package lms_pkg;

    localparam int WIDTH = 8;

    typedef logic signed [WIDTH-1:0] sample_t;

    // One guard bit is enough: the sum of two WIDTH-bit values cannot overflow WIDTH+1 bits.
    function automatic sample_t sat_sub(input sample_t a, input sample_t b);
        logic signed [WIDTH:0] diff;
        diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (diff[WIDTH] != diff[WIDTH-1])
            sat_sub = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            sat_sub = diff[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/lms_error_align_if.sv
// Sample bus between the desired/FIR sources and the error stage.
// Valid-only: the error stage never stalls its producers.
interface lms_error_align_if;
    import lms_pkg::*;

    sample_t d_in;
    logic    d_valid;
    sample_t y_in;
    logic    y_valid;
    sample_t e_out;
    sample_t e_mu_out;
    logic    e_valid;

    modport master (
        output d_in, d_valid, y_in, y_valid,
        input  e_out, e_mu_out, e_valid
    );

    modport slave (
        input  d_in, d_valid, y_in, y_valid,
        output e_out, e_mu_out, e_valid
    );

endinterface

// File: rtl/lms_sample_fifo.sv
// Synchronous show-ahead FIFO; dout is the head combinationally, pop takes effect on the edge.
// Push while full is only accepted together with a pop; pop while empty is ignored.
module lms_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + (AW+1)'(1);
            if (rd_en) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/lms_error_align.sv
// Aligns buffered d[n] with y[n] and emits saturated e[n] and e[n]>>>MU_SHIFT one cycle after y_valid.
// No backpressure: overflow/underflow drop the event and raise sticky flags; ERR_ENERGY_EN adds err_energy.
module lms_error_align
    import lms_pkg::*;
#(
    parameter int N        = 20,
    parameter int WIDTH    = lms_pkg::WIDTH,
    parameter int DEPTH    = 8,
    parameter int MU_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lms_error_align_if.slave         bus,
`ifdef ERR_ENERGY_EN
    output logic [2*WIDTH+$clog2(N+1)-1:0] err_energy,
`endif
    output logic [$clog2(N+1)-1:0]   sample_cnt,
    output logic                     done,
    output logic                     ovf,
    output logic                     unf
);
    localparam int CW = $clog2(N+1);

    logic    full;
    logic    empty;
    logic    pop;
    logic    push;
    sample_t d_head;
    sample_t e_next;

    assign pop    = bus.y_valid && !empty;
    assign push   = bus.d_valid && (!full || pop);
    assign e_next = sat_sub(d_head, bus.y_in);

    lms_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_dfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.d_in),
        .dout  (d_head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.e_out    <= '0;
            bus.e_mu_out <= '0;
            bus.e_valid  <= 1'b0;
            sample_cnt   <= '0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            unf          <= 1'b0;
        end else begin
            bus.e_valid <= pop;
            if (pop) begin
                bus.e_out    <= e_next;
                bus.e_mu_out <= e_next >>> MU_SHIFT;
                if (sample_cnt != CW'(N))   sample_cnt <= sample_cnt + CW'(1);
                if (sample_cnt == CW'(N-1)) done       <= 1'b1;
            end
            if (bus.d_valid && full && !pop) ovf <= 1'b1;
            if (bus.y_valid && empty)        unf <= 1'b1;
        end
    end

`ifdef ERR_ENERGY_EN
    localparam int EW = 2*WIDTH + CW;

    logic                      done_d;
    logic signed [2*WIDTH-1:0] e_sq;

    assign e_sq = (2*WIDTH)'(bus.e_out) * (2*WIDTH)'(bus.e_out);

    // done_d lets the N-th error (whose e_valid coincides with done) still be accumulated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_energy <= '0;
            done_d     <= 1'b0;
        end else begin
            done_d <= done;
            if (bus.e_valid && !done_d) err_energy <= err_energy + EW'($unsigned(e_sq));
        end
    end
`endif

endmodule

// File: tb/tb_lms_error_align.sv
// Scoreboard bench for lms_error_align: directed scenarios plus random traffic against a queue model.
module tb_lms_error_align;
    import lms_pkg::*;

    localparam int N     = 20;
    localparam int DEPTH = 8;
    localparam int MU    = 3;
    localparam int CW    = $clog2(N+1);

    typedef struct {
        int e;
        int emu;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lms_error_align_if bus();
    logic [CW-1:0] sample_cnt;
    logic          done;
    logic          ovf;
    logic          unf;
`ifdef ERR_ENERGY_EN
    logic [2*WIDTH+CW-1:0] err_energy;
`endif

    lms_error_align #(
        .N        (N),
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MU_SHIFT (MU)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef ERR_ENERGY_EN
        .err_energy (err_energy),
`endif
        .sample_cnt (sample_cnt),
        .done       (done),
        .ovf        (ovf),
        .unf        (unf)
    );

    // Reference state: what the DUT should show after the most recent clock edge.
    int     dq[$];
    exp_t   sbq[$];
    int     m_e, m_emu, m_cnt;
    bit     m_ev, m_done, m_ovf, m_unf;
    longint m_energy, m_pend;
    int     n_checks = 0;
    int     n_errors = 0;

    function automatic int clamp(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        dq.delete();
        sbq.delete();
        m_e = 0; m_emu = 0; m_cnt = 0;
        m_ev = 0; m_done = 0; m_ovf = 0; m_unf = 0;
        m_energy = 0; m_pend = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        chk("scoreboard_drained_before_reset", sbq.size(), 0);
        rst_n = 1'b0;
        bus.d_valid = 1'b0; bus.y_valid = 1'b0;
        bus.d_in = '0;      bus.y_in = '0;
        model_reset();
    endtask

    task automatic step(input bit dv, input int d, input bit yv, input int y);
        int   occ;
        int   h;
        int   e;
        bit   popk;
        exp_t x;
        @(posedge clk); #2;
        rst_n       = 1'b1;
        bus.d_valid = dv;
        bus.d_in    = sample_t'(d);
        bus.y_valid = yv;
        bus.y_in    = sample_t'(y);

        occ  = dq.size();
        popk = yv && (occ > 0);
        m_energy += m_pend;
        m_pend = 0;
        m_ev = popk;
        if (popk) begin
            h     = dq.pop_front();
            e     = clamp(h - y);
            x.e   = e;
            x.emu = e >>> MU;
            sbq.push_back(x);
            m_e   = x.e;
            m_emu = x.emu;
            if (m_cnt < N) begin
                m_pend = longint'(e) * longint'(e);
                m_cnt++;
                if (m_cnt == N) m_done = 1;
            end
        end
        if (yv && occ == 0) m_unf = 1;
        if (dv) begin
            if (occ < DEPTH || popk) dq.push_back(d);
            else                     m_ovf = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Monitor: consumes one scoreboard entry per e_valid and checks sticky status every cycle.
    always @(posedge clk) begin : mon
        exp_t x;
        #1;
        chk("e_valid", bus.e_valid, m_ev);
        if (bus.e_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_e_valid: got e_out=%0d, expected no output at %0t", bus.e_out, $time);
            end else begin
                x = sbq.pop_front();
                chk("e_out", bus.e_out, x.e);
                chk("e_mu_out", bus.e_mu_out, x.emu);
            end
        end else begin
            chk("e_out_hold", bus.e_out, m_e);
            chk("e_mu_out_hold", bus.e_mu_out, m_emu);
        end
        chk("sample_cnt", sample_cnt, m_cnt);
        chk("done", done, m_done);
        chk("ovf", ovf, m_ovf);
        chk("unf", unf, m_unf);
`ifdef ERR_ENERGY_EN
        chk("err_energy", err_energy, m_energy);
`endif
    end

    initial begin
        bus.d_valid = 1'b0; bus.y_valid = 1'b0;
        bus.d_in = '0;      bus.y_in = '0;
        model_reset();
        do_reset();

        // Basic alignment: d=10,20,30 then y=4,25,30.
        step(1, 10, 0, 0); step(1, 20, 0, 0); step(1, 30, 0, 0);
        step(0, 0, 1, 4);  step(0, 0, 1, 25); step(0, 0, 1, 30);
        idle(2);

        // Saturation at both rails.
        step(1, 127, 0, 0); step(1, -128, 0, 0);
        step(0, 0, 1, -128); step(0, 0, 1, 127);
        idle(2);

        // Overflow: 9th push dropped, 8 pops return the first 8, then underflow.
        do_reset();
        for (int i = 0; i < 9; i++) step(1, i*10 + 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        idle(2);

        // Full FIFO with push and pop in the same cycle keeps occupancy and ovf clear.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, -i*7, 0, 0);
        step(1, 99, 1, 5);
        for (int i = 0; i < 8; i++) step(0, 0, 1, i);
        step(0, 0, 1, 0);
        idle(2);

        // Count saturates at N; the 21st pair still produces an error.
        do_reset();
        for (int i = 0; i < N + 1; i++) begin
            step(1, i*5 - 50, 0, 0);
            step(0, 0, 1, i*3 - 20);
        end
        idle(2);

        // Reset mid-run discards buffered samples.
        do_reset();
        step(1, 11, 0, 0); step(1, 22, 0, 0); step(1, 33, 0, 0);
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 1, 9);
        idle(2);

        // Energy scenario: e = 3 then -4.
        do_reset();
        step(1, 3, 0, 0); step(1, -4, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        idle(3);

        // Random traffic with periodic resets.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int i = 0; i < 120; i++) begin
                step($urandom_range(0, 99) < 55, int'($urandom_range(0, 255)) - 128,
                     $urandom_range(0, 99) < 48, int'($urandom_range(0, 255)) - 128);
            end
            idle(3);
        end

        idle(3);
        @(posedge clk); #2;
        chk("scoreboard_empty_at_end", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
